gray_counter_ctrl: RTL and testbench

Run/stop/step/clear controller that sequences the N-bit Gray counter. It debounces three push-buttons and runs a programmable-rate prescaler. It drives the counter's clock-enable and a synchronous clear. It replaces the free-running pulse generator in the LED counter system: `clk_en` feeds `gray_Nbits.clk_en`, and `cnt_clr` is ORed into the counter's `rst`.

---
 rtl/gray_counter_ctrl_if.sv | 34 +++
 rtl/gray_counter_ctrl.sv | 155 +++++++++++++++
 tb/tb_gray_counter_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_ctrl_if.sv
// Button, rate and counter-control signals between the
// run/stop/step/clear controller and its surroundings.
interface gray_counter_ctrl_if;
    logic       btn_run;
    logic       btn_step;
    logic       btn_clr;
    logic [1:0] speed;
    logic       clk_en;
    logic       cnt_clr;
    logic       running;
    logic [1:0] state;

    modport master (
        output btn_run,
        output btn_step,
        output btn_clr,
        output speed,
        input  clk_en,
        input  cnt_clr,
        input  running,
        input  state
    );

    modport slave (
        input  btn_run,
        input  btn_step,
        input  btn_clr,
        input  speed,
        output clk_en,
        output cnt_clr,
        output running,
        output state
    );
endinterface

// File: rtl/gray_counter_ctrl.sv
// Run/stop/step/clear sequencer for the Gray counter: debounced
// buttons, programmable-rate prescaler, registered strobes.
module gray_counter_ctrl #(
    parameter int DIST      = 100000000,
    parameter int DB_CYCLES = 1000000
) (
    input logic                clk,
    input logic                rst,
    gray_counter_ctrl_if.slave bus
);
    localparam int PW = $clog2(DIST + 1);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0] DIST_V = PW'(DIST);
    localparam logic [CW-1:0] DB_V   = CW'(DB_CYCLES);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        STEP    = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] evt;

    assign raw = {bus.btn_clr, bus.btn_run, bus.btn_step};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // armed=1 waits for a stable high, armed=0 for a stable low
    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          armed;
        logic          ev;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt   <= '0;
                armed <= 1'b1;
                ev    <= 1'b0;
            end else begin
                ev <= 1'b0;
                if (sync2[i] == armed) begin
                    if (cnt == DB_V) begin
                        cnt   <= '0;
                        armed <= ~armed;
                        ev    <= armed;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign evt[i] = ev;
    end

    logic clr_e;
    logic run_e;
    logic step_e;

    assign clr_e  = evt[2];
    assign run_e  = evt[1] & ~evt[2];
    assign step_e = evt[0] & ~evt[1] & ~evt[2];

    state_t        state_q;
    state_t        state_n;
    state_t        ret_q;
    state_t        ret_n;
    logic [PW-1:0] div_q;
    logic [PW-1:0] div_n;
    logic [PW-1:0] period;
    logic          tick;
    logic          clk_en_q;
    logic          clk_en_n;
    logic          cnt_clr_q;
    logic          cnt_clr_n;
    logic          running_q;
    logic          running_n;

    assign period = DIST_V >> {bus.speed, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STOPPED;
            ret_q     <= STOPPED;
            div_q     <= '0;
            clk_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            ret_q     <= ret_n;
            div_q     <= div_n;
            clk_en_q  <= clk_en_n;
            cnt_clr_q <= cnt_clr_n;
            running_q <= running_n;
        end
    end

    always_comb begin
        state_n = state_q;
        ret_n   = ret_q;
        div_n   = '0;
        tick    = 1'b0;
        unique case (state_q)
            STOPPED: begin
                unique case (1'b1)
                    clr_e: begin
                        state_n = CLEAR;
                        ret_n   = STOPPED;
                    end
                    run_e:   state_n = RUNNING;
                    step_e:  state_n = STEP;
                    default: ;
                endcase
            end
            RUNNING: begin
                // >= lets a faster speed take effect at once
                tick = div_q >= period - 1'b1;
                unique case (1'b1)
                    clr_e: begin
                        state_n = CLEAR;
                        ret_n   = RUNNING;
                    end
                    run_e:   state_n = STOPPED;
                    default: div_n = tick ? '0 : div_q + 1'b1;
                endcase
            end
            STEP:  state_n = STOPPED;
            CLEAR: state_n = ret_q;
        endcase
        clk_en_n  = (state_n == STEP) |
                    (state_q == RUNNING && state_n == RUNNING && tick);
        cnt_clr_n = state_n == CLEAR;
        running_n = state_n == RUNNING;
    end

    assign bus.clk_en  = clk_en_q;
    assign bus.cnt_clr = cnt_clr_q;
    assign bus.running = running_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Scoreboard bench for gray_counter_ctrl: a behavioural model predicts
// every output change; a monitor pops and compares each DUT change.
module tb_gray_counter_ctrl;
    localparam int DIST = 64;
    localparam int DB   = 4;
    localparam logic [1:0] S_STOP = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_CLR  = 2'd3;

    typedef struct {
        int         cyc;
        logic [4:0] o;
    } rec_t;

    logic clk;
    logic rst;

    gray_counter_ctrl_if bus ();

    gray_counter_ctrl #(
        .DIST      (DIST),
        .DB_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rec_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   done = 0;
    bit   wait_expired = 0;

    // model state
    logic [1:0] m_st;
    logic [1:0] m_ret;
    int         m_el;
    int         per;
    bit         m_ce;
    bit         m_cc;
    bit         m_s1[3];
    bit         m_s2[3];
    bit         m_arm[3];
    bit         m_ev[3];
    bit         m_raw[3];
    int         m_hi[3];
    int         m_lo[3];
    bit         e_clr;
    bit         e_run;
    bit         e_step;
    logic [4:0] exp_o;
    logic [4:0] exp_prev = 5'h1f;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_st  = S_STOP;
            m_ret = S_STOP;
            m_el  = 0;
            m_ce  = 0;
            m_cc  = 0;
            for (int b = 0; b < 3; b++) begin
                m_s1[b]  = 0;
                m_s2[b]  = 0;
                m_hi[b]  = 0;
                m_lo[b]  = 0;
                m_arm[b] = 1;
                m_ev[b]  = 0;
            end
        end else begin
            per    = DIST >> (2 * int'(bus.speed));
            e_clr  = m_ev[2];
            e_run  = m_ev[1] && !m_ev[2];
            e_step = m_ev[0] && !m_ev[1] && !m_ev[2];
            m_ce   = 0;
            m_cc   = 0;
            case (m_st)
                S_STOP: begin
                    if (e_clr) begin
                        m_st  = S_CLR;
                        m_ret = S_STOP;
                    end else if (e_run) begin
                        m_st = S_RUN;
                        m_el = 0;
                    end else if (e_step) begin
                        m_st = S_STEP;
                    end
                end
                S_RUN: begin
                    m_el = m_el + 1;
                    if (e_clr) begin
                        m_st  = S_CLR;
                        m_ret = S_RUN;
                    end else if (e_run) begin
                        m_st = S_STOP;
                    end else if (m_el >= per) begin
                        m_ce = 1;
                        m_el = 0;
                    end
                end
                S_STEP: m_st = S_STOP;
                default: begin
                    m_st = m_ret;
                    m_el = 0;
                end
            endcase
            if (m_st == S_STEP) m_ce = 1;
            if (m_st == S_CLR) m_cc = 1;
            m_raw[0] = bus.btn_step;
            m_raw[1] = bus.btn_run;
            m_raw[2] = bus.btn_clr;
            // press = DB+1 consecutive high samples while armed
            for (int b = 0; b < 3; b++) begin
                if (m_s2[b]) begin
                    m_hi[b] = m_hi[b] + 1;
                    m_lo[b] = 0;
                end else begin
                    m_lo[b] = m_lo[b] + 1;
                    m_hi[b] = 0;
                end
                m_ev[b] = 0;
                if (m_arm[b] && m_hi[b] >= DB + 1) begin
                    m_ev[b]  = 1;
                    m_arm[b] = 0;
                end else if (!m_arm[b] && m_lo[b] >= DB + 1) begin
                    m_arm[b] = 1;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = m_raw[b];
            end
        end
        exp_o = {m_st, m_st == S_RUN, m_ce, m_cc};
        if (exp_o != exp_prev) sb.push_back('{cyc, exp_o});
        exp_prev = exp_o;
    end

    logic [4:0] mon_o;
    logic [4:0] mon_prev = 5'h1f;
    rec_t       r;

    always @(negedge clk) begin
        mon_o = {bus.state, bus.running, bus.clk_en, bus.cnt_clr};
        if (mon_o !== mon_prev) begin
            tests = tests + 1;
            if (sb.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_change cyc=%0d got=%b required no change",
                         cyc, mon_o);
            end else begin
                r = sb.pop_front();
                if (r.cyc != cyc || r.o !== mon_o) begin
                    fails = fails + 1;
                    $display("FAIL out_change got cyc=%0d {st,run,ce,cc}=%b required cyc=%0d %b",
                             cyc, mon_o, r.cyc, r.o);
                end
            end
        end
        mon_prev = mon_o;
        if (done) begin
            tests = tests + 1;
            if (sb.size() != 0) begin
                fails = fails + 1;
                $display("FAIL missing_changes got %0d pending required 0 (next cyc=%0d %b)",
                         sb.size(), sb[0].cyc, sb[0].o);
            end
            tests = tests + 1;
            if (wait_expired) begin
                fails = fails + 1;
                $display("FAIL clear_wait got timeout required state=3");
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit [2:0] m, input int hold, input int gap);
        @(negedge clk);
        {bus.btn_clr, bus.btn_run, bus.btn_step} = m;
        repeat (hold) @(negedge clk);
        {bus.btn_clr, bus.btn_run, bus.btn_step} = 3'b000;
        repeat (gap) @(negedge clk);
    endtask

    int  k;
    int  sel;
    bit [2:0] msk;

    initial begin
        rst = 1'b1;
        bus.speed = 2'd0;
        {bus.btn_clr, bus.btn_run, bus.btn_step} = 3'b111;
        cycles(3);
        {bus.btn_clr, bus.btn_run, bus.btn_step} = 3'b000;
        cycles(5);
        rst = 1'b0;
        cycles(20);

        press(3'b010, 8, 10);
        cycles(200);
        bus.speed = 2'd3;
        cycles(10);
        press(3'b010, 8, 20);

        bus.speed = 2'd0;
        press(3'b001, 3, 15);
        press(3'b001, 10, 15);
        press(3'b010, 8, 20);
        press(3'b001, 10, 30);
        press(3'b010, 8, 20);

        press(3'b010, 8, 30);
        press(3'b100, 8, 100);
        press(3'b010, 8, 20);
        press(3'b100, 8, 20);

        press(3'b110, 8, 20);

        bus.speed = 2'd2;
        press(3'b010, 8, 20);
        @(negedge clk);
        bus.btn_clr = 1'b1;
        k = 0;
        while (bus.state != 2'd3 && k < 40) begin
            @(negedge clk);
            k = k + 1;
        end
        if (k >= 40) wait_expired = 1;
        rst = 1'b1;
        bus.btn_clr = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(20);

        repeat (160) begin
            sel = $urandom_range(0, 11);
            if (sel == 0) begin
                @(negedge clk);
                rst = 1'b1;
                cycles($urandom_range(1, 3));
                rst = 1'b0;
            end else if (sel == 1) begin
                @(negedge clk);
                bus.speed = 2'($urandom_range(0, 3));
            end else if (sel == 2) begin
                cycles($urandom_range(50, 150));
            end else begin
                if ($urandom_range(0, 3) == 0)
                    msk = 3'($urandom_range(1, 7));
                else
                    msk = 3'(1 << $urandom_range(0, 2));
                press(msk, $urandom_range(1, 10), $urandom_range(1, 40));
            end
        end
        {bus.btn_clr, bus.btn_run, bus.btn_step} = 3'b000;
        rst = 1'b0;
        cycles(100);
        done = 1;
    end
endmodule
